exec_alu: RTL and testbench
===========================

# exec_alu

Execute-stage ALU for the MIPS pipeline, directly downstream of the ALU control decoder: consumes its 6-bit ALUControl code plus the two operands and shift amount, and produces a registered result and branch/zero flag. Single-cycle operations complete in one clock. MUL runs on an iterative shift-add multiplier and holds the pipeline through a Stall output. Results go to the EX/MEM register.

## Interface
- DATA_WIDTH, 32, operand/result width
- MUL_ITERS, DATA_WIDTH, multiplier iterations (one bit per clock)

- Clk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-high
- InValid  in  1  operation present on inputs this cycle
- ALUControl  in  6  operation code from the ALU control decoder
- A  in  DATA_WIDTH  operand rs
- B  in  DATA_WIDTH  operand rt / immediate
- Shamt  in  5  shift amount for SLL/SRL
- Flush  in  1  abort in-flight op, discard current input
- ALUResult  out  DATA_WIDTH  registered result
- Zero  out  1  registered flag (see Operation)
- ResultValid  out  1  one-cycle pulse, ALUResult/Zero valid
- Stall  out  1  unit cannot accept; upstream must hold

## Operation
- Codes: ADD 100000 A+B; SUB 100010 A-B; AND 100100; OR 100101; NOR 100111; XOR 100110; SLL 000000 B<<Shamt; SRL 000010 B>>Shamt (logical); SLT 101010 signed A<B → 1/0; JR 001000 result=A; MUL 011000 low DATA_WIDTH bits of A*B.
- Branch codes (result 0, Zero=condition): BEQ 000100 A==B; BNE 000101 A!=B; BGTZ 000111 signed A>0; BLEZ 000110 signed A<=0; BLTZ/BGEZ 000001 A[31] (branch unit inverts for BGEZ).
- J 000010, JAL 000011 and any undefined code: result 0, Zero 1, ResultValid still pulses.
- Non-branch ops: Zero = (ALUResult == 0).
- ADD/SUB wrap modulo 2^DATA_WIDTH, no overflow trap.
- FSM: IDLE, MUL.
  - IDLE & InValid & non-MUL: register result, ResultValid=1 next cycle, stay IDLE.
  - IDLE & InValid & MUL: latch A (multiplicand), B (multiplier), acc=0, count=0 → MUL.
  - MUL: each edge, if multiplier[0] add multiplicand to acc; multiplicand<<=1, multiplier>>=1, count++. On the edge where count reaches MUL_ITERS-1: write acc to ALUResult, ResultValid=1, → IDLE.
- Unsigned shift-add; low half equals signed MIPS mul result.
- Stall = (state==MUL) | (state==IDLE & InValid & ALUControl==MUL & !Flush). Combinational.
- Inputs are ignored while in MUL.
- Flush: next edge forces IDLE, ResultValid=0, and does not accept the current input. Flush wins over a simultaneous InValid or MUL completion. ALUResult/Zero hold their last values.

## Timing
- Reset (async): state IDLE, count 0, ALUResult 0, Zero 0, ResultValid 0. Stall=0 while Reset is high.
- Single-cycle op accepted at edge t: ResultValid high in cycle t..t+1 only.
- MUL accepted at edge t: iterations on edges t+1..t+MUL_ITERS.
  - ResultValid high for the cycle after edge t+MUL_ITERS.
  - Stall high from the accept cycle through edge t+MUL_ITERS, so it is low in the ResultValid cycle.
  - A new op can be accepted back-to-back in that ResultValid cycle.
- Back-to-back single-cycle ops: one result per cycle, Stall never asserted.
- Reset mid-MUL: immediate abort, no ResultValid.

## Structure
- Package alu_ops_pkg: localparams for every 6-bit ALUControl code above, shared with the ALU control decoder and the branch unit; FSM state encoding.
- Sub-module mul_iter: shift-add multiplier with start/done, Clk/Reset/Flush, parameterised on DATA_WIDTH. The top level holds the FSM handshake, the combinational op mux and the output registers.

## Test plan
- Reset mid-MUL, then ADD A=5 B=7 → ALUResult 12, Zero 0, ResultValid one cycle, Stall never high.
- SUB A=9 B=9 → result 0, Zero 1. SLT A=0xFFFFFFFF B=1 → 1. SRL B=0x80000000 Shamt=31 → 1.
- MUL A=0xFFFFFFFD (-3) B=7 → Stall high 33 cycles, result 0xFFFFFFEB, ResultValid exactly once, then accept ADD in the ResultValid cycle.
- Branches: BEQ 4,4 → Zero 1; BNE 4,4 → Zero 0; BGTZ A=0 → 0; BLEZ A=0 → 1; code 000001 A=0x80000000 → 1.
- Flush at iteration 10 of MUL 3*5 → no ResultValid, Stall low next cycle; a subsequent MUL 3*5 gives 15.
- Flush asserted together with InValid ADD → no ResultValid; an undefined code 111111 → result 0, Zero 1, ResultValid pulses.

Source files
------------

// File: rtl/alu_ops_pkg.sv
// ALU operation codes shared by the ALU control decoder, the execute-stage
// ALU and the branch unit, plus the execute-stage FSM state type.
package alu_ops_pkg;

  // Arithmetic / logic
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_MUL  = 6'b011000;

  // Branches: result 0, Zero carries the condition
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BLTZ = 6'b000001;  // also BGEZ, inverted downstream

  // Jumps: result 0, Zero 1. J shares its code with SRL; SRL takes it here.
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/exec_alu_if.sv
// Execute-stage ALU bus: operation request from the pipeline and the
// registered result/flag returned towards EX/MEM.
//   master: InValid, ALUControl, A, B, Shamt, Flush out; results in
//   slave : the ALU side
interface exec_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  InValid;
  logic [5:0]            ALUControl;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [4:0]            Shamt;
  logic                  Flush;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Zero;
  logic                  ResultValid;
  logic                  Stall;

  modport master (
    output InValid, ALUControl, A, B, Shamt, Flush,
    input  ALUResult, Zero, ResultValid, Stall
  );

  modport slave (
    input  InValid, ALUControl, A, B, Shamt, Flush,
    output ALUResult, Zero, ResultValid, Stall
  );
endinterface

// File: rtl/exec_alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per step.
//   Clk, Reset   clock, async active-high reset
//   Flush        abandon the running product (iteration count cleared)
//   start        load operands, clear accumulator and count
//   step         perform one iteration (driven by the owning FSM)
//   a, b         multiplicand, multiplier
//   done         high during the final step
//   product      low DATA_WIDTH bits of a*b, valid while done is high
module mul_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_ITERS  = DATA_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic                  start,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);
  localparam int CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_nxt;
  logic [CW-1:0]         count;

  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  // The final add is taken straight from acc_nxt so the result can be
  // registered on the same edge as the last iteration.
  assign product = acc_nxt;
  assign done    = step & (count == CW'(MUL_ITERS - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (Flush) begin
      count  <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end
endmodule

// File: rtl/exec_alu.sv
// Execute-stage ALU for the MIPS pipeline. Single-cycle ops register their
// result on the accepting edge; MUL runs on mul_iter and holds the pipeline
// through Stall until its result is registered.
//   Clk          clock, all state on rising edge
//   Reset        asynchronous, active-high
//   bus (slave)  InValid/ALUControl/A/B/Shamt/Flush in;
//                ALUResult/Zero/ResultValid (registered), Stall (comb) out
module exec_alu
  import alu_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_ITERS  = DATA_WIDTH
) (
  input  logic       Clk,
  input  logic       Reset,
  exec_alu_if.slave  bus
);
  alu_state_e            state;
  alu_state_e            state_nxt;
  logic                  is_mul;
  logic                  accept_op;
  logic                  mul_start;
  logic                  mul_step;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [DATA_WIDTH-1:0] op_res;
  logic                  op_zero;
  logic                  branch_op;

  assign is_mul = (bus.ALUControl == OP_MUL);

  // Combinational op mux for single-cycle operations
  always_comb begin
    op_res    = '0;
    op_zero   = 1'b0;
    branch_op = 1'b0;
    case (bus.ALUControl)
      OP_ADD:  op_res = bus.A + bus.B;
      OP_SUB:  op_res = bus.A - bus.B;
      OP_AND:  op_res = bus.A & bus.B;
      OP_OR:   op_res = bus.A | bus.B;
      OP_NOR:  op_res = ~(bus.A | bus.B);
      OP_XOR:  op_res = bus.A ^ bus.B;
      OP_SLL:  op_res = bus.B << bus.Shamt;
      OP_SRL:  op_res = bus.B >> bus.Shamt;
      OP_SLT:  op_res[0] = ($signed(bus.A) < $signed(bus.B));
      OP_JR:   op_res = bus.A;
      OP_BEQ:  begin branch_op = 1'b1; op_zero = (bus.A == bus.B); end
      OP_BNE:  begin branch_op = 1'b1; op_zero = (bus.A != bus.B); end
      OP_BGTZ: begin
        branch_op = 1'b1;
        op_zero   = ~bus.A[DATA_WIDTH-1] & (bus.A != '0);
      end
      OP_BLEZ: begin
        branch_op = 1'b1;
        op_zero   = bus.A[DATA_WIDTH-1] | (bus.A == '0);
      end
      OP_BLTZ: begin branch_op = 1'b1; op_zero = bus.A[DATA_WIDTH-1]; end
      // JAL and undefined codes leave result 0, so Zero below becomes 1
      default: op_res = '0;
    endcase
    if (!branch_op) op_zero = (op_res == '0);
  end

  // FSM: state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.InValid && !bus.Flush && is_mul) state_nxt = ST_MUL;
      ST_MUL:  if (bus.Flush || mul_done)               state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. Stall is gated by Reset since the accept term is
  // combinational from the inputs.
  always_comb begin
    accept_op = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    bus.Stall = 1'b0;
    case (state)
      ST_IDLE: begin
        accept_op = bus.InValid & ~bus.Flush & ~is_mul;
        mul_start = bus.InValid & ~bus.Flush & is_mul;
        bus.Stall = mul_start & ~Reset;
      end
      ST_MUL: begin
        mul_step  = ~bus.Flush;
        bus.Stall = ~Reset;
      end
      default: ;
    endcase
  end

  mul_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .MUL_ITERS  (MUL_ITERS)
  ) u_mul (
    .Clk     (Clk),
    .Reset   (Reset),
    .Flush   (bus.Flush),
    .start   (mul_start),
    .step    (mul_step),
    .a       (bus.A),
    .b       (bus.B),
    .done    (mul_done),
    .product (mul_product)
  );

  // Output registers; result and flag hold when nothing completes
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.ALUResult   <= '0;
      bus.Zero        <= 1'b0;
      bus.ResultValid <= 1'b0;
    end else begin
      bus.ResultValid <= accept_op | mul_done;
      if (accept_op) begin
        bus.ALUResult <= op_res;
        bus.Zero      <= op_zero;
      end else if (mul_done) begin
        bus.ALUResult <= mul_product;
        bus.Zero      <= (mul_product == '0);
      end
    end
  end
endmodule

// File: tb/tb_exec_alu.sv
module tb_exec_alu;
  localparam int DW    = 32;
  localparam int ITERS = 32;

  localparam logic [5:0] C_ADD  = 6'b100000;
  localparam logic [5:0] C_SUB  = 6'b100010;
  localparam logic [5:0] C_SLT  = 6'b101010;
  localparam logic [5:0] C_SRL  = 6'b000010;
  localparam logic [5:0] C_MUL  = 6'b011000;
  localparam logic [5:0] C_BEQ  = 6'b000100;
  localparam logic [5:0] C_BNE  = 6'b000101;
  localparam logic [5:0] C_BGTZ = 6'b000111;
  localparam logic [5:0] C_BLEZ = 6'b000110;
  localparam logic [5:0] C_BLTZ = 6'b000001;

  logic clk;
  logic rst;

  exec_alu_if #(.DATA_WIDTH(DW)) bus ();

  exec_alu #(.DATA_WIDTH(DW), .MUL_ITERS(ITERS)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_left;   // edges of multiply still to go (0 = idle)
  logic [DW-1:0] m_ma, m_mb, m_res;
  logic        m_zero, m_valid;

  // Values sampled at the most recent negedge
  logic          last_rv, last_zero, last_stall;
  logic [DW-1:0] last_res;
  int            rv_total, stall_total;

  logic [5:0] codes [19] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b100111, 6'b100110, 6'b000000, 6'b000010,
                             6'b101010, 6'b001000, 6'b011000, 6'b000100,
                             6'b000101, 6'b000111, 6'b000110, 6'b000001,
                             6'b000011, 6'b111111, 6'b010101};

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {zero, result} for a single-cycle operation.
  function automatic logic [DW:0] ref_op(input logic [5:0] c, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b, input logic [4:0] sh);
    logic [DW-1:0] r;
    logic z;
    logic br;
    r = '0; z = 1'b0; br = 1'b0;
    case (c)
      6'b100000: r = a + b;
      6'b100010: r = a - b;
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100111: r = ~(a | b);
      6'b100110: r = a ^ b;
      6'b000000: r = b << sh;
      6'b000010: r = b >> sh;
      6'b101010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b001000: r = a;
      6'b000100: begin br = 1'b1; z = (a == b); end
      6'b000101: begin br = 1'b1; z = (a != b); end
      6'b000111: begin br = 1'b1; z = ($signed(a) > 0); end
      6'b000110: begin br = 1'b1; z = ($signed(a) <= 0); end
      6'b000001: begin br = 1'b1; z = a[DW-1]; end
      default:   r = '0;
    endcase
    if (!br) z = (r == '0);
    return {z, r};
  endfunction

  // One clock: sample and compare at negedge, advance the model over the
  // coming rising edge, return just after that edge.
  task automatic tick();
    logic exp_stall;
    logic [DW:0] zr;
    logic [2*DW-1:0] full;
    @(negedge clk);
    last_rv    = bus.ResultValid;
    last_res   = bus.ALUResult;
    last_zero  = bus.Zero;
    last_stall = bus.Stall;
    if (last_rv)    rv_total++;
    if (last_stall) stall_total++;
    if (rst) begin
      chk1("reset_valid", last_rv, 1'b0);
      chk ("reset_result", last_res, '0);
      chk1("reset_zero", last_zero, 1'b0);
      chk1("reset_stall", last_stall, 1'b0);
      m_left = 0; m_valid = 1'b0; m_res = '0; m_zero = 1'b0;
    end else begin
      exp_stall = (m_left > 0) || (bus.InValid && bus.ALUControl == C_MUL && !bus.Flush);
      chk1("valid", last_rv, m_valid);
      chk ("result", last_res, m_res);
      chk1("zero", last_zero, m_zero);
      chk1("stall", last_stall, exp_stall);
      m_valid = 1'b0;
      if (bus.Flush) begin
        m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          full    = {{DW{1'b0}}, m_ma} * {{DW{1'b0}}, m_mb};
          m_res   = full[DW-1:0];
          m_zero  = (m_res == '0);
          m_valid = 1'b1;
        end
      end else if (bus.InValid) begin
        if (bus.ALUControl == C_MUL) begin
          m_left = ITERS;
          m_ma   = bus.A;
          m_mb   = bus.B;
        end else begin
          zr      = ref_op(bus.ALUControl, bus.A, bus.B, bus.Shamt);
          m_res   = zr[DW-1:0];
          m_zero  = zr[DW];
          m_valid = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [5:0] c, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [4:0] sh, input logic f);
    bus.InValid    = v;
    bus.ALUControl = c;
    bus.A          = a;
    bus.B          = b;
    bus.Shamt      = sh;
    bus.Flush      = f;
  endtask

  // Issue a single-cycle op; afterwards last_* hold the result cycle.
  task automatic op1(input logic [5:0] c, input logic [DW-1:0] a,
                     input logic [DW-1:0] b, input logic [4:0] sh);
    set_in(1'b1, c, a, b, sh, 1'b0);
    tick();
    set_in(1'b0, 6'b0, '0, '0, 5'd0, 1'b0);
    tick();
  endtask

  initial begin : main
    int rv0, st0;
    logic [5:0] c;
    logic [DW-1:0] a, b;
    m_left = 0; m_valid = 1'b0; m_res = '0; m_zero = 1'b0; m_ma = '0; m_mb = '0;
    rv_total = 0; stall_total = 0;
    rst = 1'b1;
    set_in(1'b0, 6'b0, '0, '0, 5'd0, 1'b0);
    tick();
    // Stall must stay low under reset even with a MUL presented
    set_in(1'b1, C_MUL, 32'd3, 32'd5, 5'd0, 1'b0);
    tick();
    chk1("stall_in_reset", last_stall, 1'b0);
    rst = 1'b0;
    tick();                                   // MUL accepted here
    set_in(1'b0, 6'b0, '0, '0, 5'd0, 1'b0);
    repeat (5) tick();
    rv0 = rv_total;
    rst = 1'b1;
    tick();
    chk1("midmul_reset_stall", last_stall, 1'b0);
    rst = 1'b0;
    repeat (2) tick();
    chk("midmul_reset_no_valid", rv_total - rv0, 0);

    st0 = stall_total;
    op1(C_ADD, 32'd5, 32'd7, 5'd0);
    chk ("add_result", last_res, 32'd12);
    chk1("add_zero", last_zero, 1'b0);
    chk1("add_valid", last_rv, 1'b1);
    tick();
    chk1("add_pulse_len", last_rv, 1'b0);
    chk ("add_no_stall", stall_total - st0, 0);

    op1(C_SUB, 32'd9, 32'd9, 5'd0);
    chk ("sub_result", last_res, 32'd0);
    chk1("sub_zero", last_zero, 1'b1);
    op1(C_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk ("slt_result", last_res, 32'd1);
    op1(C_SRL, 32'd0, 32'h8000_0000, 5'd31);
    chk ("srl_result", last_res, 32'd1);

    // MUL -3*7 with an ADD accepted in the ResultValid cycle
    st0 = stall_total; rv0 = rv_total;
    set_in(1'b1, C_MUL, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b0);
    tick();
    set_in(1'b0, 6'b0, '0, '0, 5'd0, 1'b0);
    repeat (ITERS) tick();
    set_in(1'b1, C_ADD, 32'd1, 32'd2, 5'd0, 1'b0);
    tick();
    chk1("mul_valid", last_rv, 1'b1);
    chk ("mul_result", last_res, 32'hFFFF_FFEB);
    chk1("mul_valid_cycle_stall", last_stall, 1'b0);
    chk ("mul_stall_cycles", stall_total - st0, 33);
    chk ("mul_valid_once", rv_total - rv0, 1);
    set_in(1'b0, 6'b0, '0, '0, 5'd0, 1'b0);
    tick();
    chk ("b2b_add_result", last_res, 32'd3);
    chk1("b2b_add_valid", last_rv, 1'b1);

    op1(C_BEQ, 32'd4, 32'd4, 5'd0);
    chk1("beq_zero", last_zero, 1'b1);
    chk ("beq_result", last_res, 32'd0);
    op1(C_BNE, 32'd4, 32'd4, 5'd0);
    chk1("bne_zero", last_zero, 1'b0);
    op1(C_BGTZ, 32'd0, 32'd0, 5'd0);
    chk1("bgtz_zero", last_zero, 1'b0);
    op1(C_BLEZ, 32'd0, 32'd0, 5'd0);
    chk1("blez_zero", last_zero, 1'b1);
    op1(C_BLTZ, 32'h8000_0000, 32'd0, 5'd0);
    chk1("bltz_zero", last_zero, 1'b1);

    // Flush during iteration 10 of MUL 3*5
    rv0 = rv_total;
    set_in(1'b1, C_MUL, 32'd3, 32'd5, 5'd0, 1'b0);
    tick();
    set_in(1'b0, 6'b0, '0, '0, 5'd0, 1'b0);
    repeat (9) tick();
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    tick();
    chk1("flush_stall_low", last_stall, 1'b0);
    repeat (ITERS) tick();
    chk ("flush_no_valid", rv_total - rv0, 0);
    set_in(1'b1, C_MUL, 32'd3, 32'd5, 5'd0, 1'b0);
    tick();
    set_in(1'b0, 6'b0, '0, '0, 5'd0, 1'b0);
    repeat (ITERS) tick();
    tick();
    chk1("mul2_valid", last_rv, 1'b1);
    chk ("mul2_result", last_res, 32'd15);

    // Flush with a simultaneous ADD, then an undefined code
    set_in(1'b1, C_ADD, 32'd5, 32'd7, 5'd0, 1'b1);
    tick();
    set_in(1'b0, 6'b0, '0, '0, 5'd0, 1'b0);
    tick();
    chk1("flush_add_no_valid", last_rv, 1'b0);
    chk ("flush_add_hold", last_res, 32'd15);
    op1(6'b111111, 32'd5, 32'd7, 5'd0);
    chk ("undef_result", last_res, 32'd0);
    chk1("undef_zero", last_zero, 1'b1);
    chk1("undef_valid", last_rv, 1'b1);

    // Randomized traffic; the per-cycle model comparison does the checking
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 9) == 0) ? 6'($urandom) : codes[$urandom_range(0, 18)];
      a = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
      b = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      set_in($urandom_range(0, 9) < 6, c, a, b, 5'($urandom), $urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0;
    set_in(1'b0, 6'b0, '0, '0, 5'd0, 1'b0);
    repeat (ITERS + 2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
